vga_pixel_writer: RTL and testbench

VGA_PIXEL_WRITER -- requirements
Module: vga_pixel_writer

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_fb_addr.sv | 20 ++
 rtl/vga_pixel_writer.sv | 201 ++++++++++++++++++++
 tb/tb_vga_pixel_writer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer pixel writer and display reader.
// Optional clear sequence is enabled with the VGA_CLEAR_EN macro.
package vga_pkg;

  // Word address of framebuffer word 0 and framebuffer geometry
  localparam logic [31:0] WORD_ADDRESS_BASE_DEFAULT = 32'h3E80;
  localparam int          FB_ROWS_DEFAULT           = 96;
  localparam int          FB_WORDS                  = 4 * FB_ROWS_DEFAULT;  // 384

  // Display bus phase encodings
  localparam logic [1:0] VGA_INACTIVE   = 2'd0;
  localparam logic [1:0] VGA_PRE_ACTIVE = 2'd1;
  localparam logic [1:0] VGA_ACTIVE     = 2'd2;

  // Pixel writer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_WRITE_REQ,
    ST_WRITE_WAIT
`ifdef VGA_CLEAR_EN
    , ST_CLEAR
`endif
  } wr_state_t;

endpackage

// File: rtl/vga_fb_addr.sv
// Framebuffer address map: pixel (x, y) -> SRAM word address and bit index.
// Shared with the display reader so both sides agree on the bit order.
module vga_fb_addr
  import vga_pkg::*;
#(
  parameter logic [31:0] WORD_ADDRESS_BASE = WORD_ADDRESS_BASE_DEFAULT
) (
  input  logic [6:0]  i_x,
  input  logic [6:0]  i_y,
  output logic [31:0] o_word_addr,
  output logic [4:0]  o_bit_idx
);

  // Four 32-bit words per 128-pixel row; x[6:5] selects the word in the row
  assign o_word_addr = WORD_ADDRESS_BASE + {23'd0, i_y, 2'b00} + {30'd0, i_x[6:5]};

  // The display shifts words out LSB-first in reversed 5-bit order
  assign o_bit_idx = {i_x[0], i_x[1], i_x[2], i_x[3], i_x[4]};

endmodule

// File: rtl/vga_pixel_writer.sv
// Read-modify-write of single framebuffer pixels in SRAM, deferred while the
// display owns the bus. Optional full-framebuffer clear with VGA_CLEAR_EN.
module vga_pixel_writer
  import vga_pkg::*;
#(
  parameter logic [31:0] WORD_ADDRESS_BASE = WORD_ADDRESS_BASE_DEFAULT,
  parameter int          FB_ROWS           = FB_ROWS_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        pixel_valid,
  input  logic [6:0]  pixel_x,
  input  logic [6:0]  pixel_y,
  input  logic        pixel_value,
  output logic        pixel_ready,
  output logic        pixel_done,
  input  logic [1:0]  VGA_state,
  input  logic [31:0] SRAM_data_in,
  input  logic        SRAM_busy,
`ifdef VGA_CLEAR_EN
  input  logic        clear_req,
`endif
  output logic        read_en,
  output logic        write_en,
  output logic [31:0] word_address_dest,
  output logic [31:0] data_out,
  output logic [3:0]  byte_select
);

  localparam logic [7:0] ROWS8 = 8'(FB_ROWS);
`ifdef VGA_CLEAR_EN
  localparam logic [8:0] CLR_LAST = 9'(4 * FB_ROWS - 1);
`endif

  wr_state_t   r_state;
  wr_state_t   w_next;
  logic [6:0]  r_x;
  logic [6:0]  r_y;
  logic        r_value;
  logic        r_hold;
  logic        r_done;
  logic [31:0] r_data;
  logic [31:0] w_word_addr;
  logic [4:0]  w_bit_idx;
  logic [31:0] w_merged;
  logic        w_idle;
  logic        w_vga_idle;
  logic        w_in_range;
  logic        w_accept;
  logic        w_clear_start;
`ifdef VGA_CLEAR_EN
  logic [8:0]  r_clr_cnt;
  logic        r_clr_wait;
`endif

  vga_fb_addr #(
    .WORD_ADDRESS_BASE (WORD_ADDRESS_BASE)
  ) u_fb_addr (
    .i_x         (r_x),
    .i_y         (r_y),
    .o_word_addr (w_word_addr),
    .o_bit_idx   (w_bit_idx)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_vga_idle = (VGA_state == VGA_INACTIVE);
  assign w_in_range = ({1'b0, pixel_y} < ROWS8);

`ifdef VGA_CLEAR_EN
  // A clear may only start when the bus is free and no pixel is parked
  assign w_clear_start = clear_req & w_idle & ~r_hold & w_vga_idle;
`else
  assign w_clear_start = 1'b0;
`endif

  // A parked request or a starting clear blocks new pixel requests
  assign pixel_ready = w_idle & ~r_hold & ~w_clear_start;
  assign w_accept    = pixel_valid & pixel_ready;
  assign pixel_done  = r_done;

  // Read data with the target pixel replaced by the latched value
  always_comb begin
    w_merged            = SRAM_data_in;
    w_merged[w_bit_idx] = r_value;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_hold) begin
          if (w_vga_idle) w_next = ST_READ_REQ;
        end else if (w_accept && w_in_range && w_vga_idle) begin
          w_next = ST_READ_REQ;
        end
`ifdef VGA_CLEAR_EN
        else if (w_clear_start) begin
          w_next = ST_CLEAR;
        end
`endif
      end
      ST_READ_REQ:   w_next = ST_READ_WAIT;
      ST_READ_WAIT:  if (!SRAM_busy) w_next = ST_WRITE_REQ;
      ST_WRITE_REQ:  w_next = ST_WRITE_WAIT;
      ST_WRITE_WAIT: if (!SRAM_busy) w_next = ST_IDLE;
`ifdef VGA_CLEAR_EN
      ST_CLEAR:      if (r_clr_wait && !SRAM_busy && (r_clr_cnt == CLR_LAST)) w_next = ST_IDLE;
`endif
      default:       w_next = ST_IDLE;
    endcase
  end

  // Request latches, hold flag, modified word and the done pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_value <= 1'b0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_x     <= pixel_x;
        r_y     <= pixel_y;
        r_value <= pixel_value;
        if (!w_in_range)      r_done <= 1'b1;  // off-screen row: drop, no SRAM access
        else if (!w_vga_idle) r_hold <= 1'b1;  // display owns the bus: park it
      end
      if (w_idle && r_hold && w_vga_idle) r_hold <= 1'b0;
      if ((r_state == ST_READ_WAIT) && !SRAM_busy) r_data <= w_merged;
      if ((r_state == ST_WRITE_WAIT) && !SRAM_busy) r_done <= 1'b1;
`ifdef VGA_CLEAR_EN
      if (r_state == ST_CLEAR && r_clr_wait && !SRAM_busy && (r_clr_cnt == CLR_LAST)) r_done <= 1'b1;
`endif
    end
  end

`ifdef VGA_CLEAR_EN
  // Clear word counter: alternate one write cycle with a wait-for-idle phase
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_clr_cnt  <= '0;
      r_clr_wait <= 1'b0;
    end else if (w_clear_start) begin
      r_clr_cnt  <= '0;
      r_clr_wait <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      if (!r_clr_wait) begin
        r_clr_wait <= 1'b1;
      end else if (!SRAM_busy) begin
        r_clr_wait <= 1'b0;
        if (r_clr_cnt != CLR_LAST) r_clr_cnt <= r_clr_cnt + 9'd1;
      end
    end
  end
`endif

  // SRAM request outputs decoded from the current state
  always_comb begin
    read_en           = 1'b0;
    write_en          = 1'b0;
    word_address_dest = '0;
    data_out          = '0;
    case (r_state)
      ST_READ_REQ: begin
        read_en           = 1'b1;
        word_address_dest = w_word_addr;
      end
      ST_READ_WAIT:  word_address_dest = w_word_addr;
      ST_WRITE_REQ: begin
        write_en          = 1'b1;
        word_address_dest = w_word_addr;
        data_out          = r_data;
      end
      ST_WRITE_WAIT: word_address_dest = w_word_addr;
`ifdef VGA_CLEAR_EN
      ST_CLEAR: begin
        write_en          = ~r_clr_wait;
        word_address_dest = WORD_ADDRESS_BASE + {23'd0, r_clr_cnt};
      end
`endif
      default: ;
    endcase
  end

  assign byte_select = (read_en | write_en) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Self-checking bench for vga_pixel_writer: directed cases plus randomized
// pixel writes against a behavioural framebuffer model; clear sequence is
// exercised when VGA_CLEAR_EN is defined.
module tb_vga_pixel_writer;

  localparam logic [31:0] BASE  = 32'h3E80;
  localparam int          ROWS  = 96;
  localparam int          WORDS = 4 * ROWS;

  logic        clk;
  logic        nrst;
  logic        pixel_valid;
  logic [6:0]  pixel_x;
  logic [6:0]  pixel_y;
  logic        pixel_value;
  logic        pixel_ready;
  logic        pixel_done;
  logic [1:0]  VGA_state;
  logic [31:0] SRAM_data_in;
  logic        SRAM_busy;
`ifdef VGA_CLEAR_EN
  logic        clear_req;
`endif
  logic        read_en;
  logic        write_en;
  logic [31:0] word_address_dest;
  logic [31:0] data_out;
  logic [3:0]  byte_select;

  vga_pixel_writer dut (
    .clk               (clk),
    .nrst              (nrst),
    .pixel_valid       (pixel_valid),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .pixel_value       (pixel_value),
    .pixel_ready       (pixel_ready),
    .pixel_done        (pixel_done),
    .VGA_state         (VGA_state),
    .SRAM_data_in      (SRAM_data_in),
    .SRAM_busy         (SRAM_busy),
`ifdef VGA_CLEAR_EN
    .clear_req         (clear_req),
`endif
    .read_en           (read_en),
    .write_en          (write_en),
    .word_address_dest (word_address_dest),
    .data_out          (data_out),
    .byte_select       (byte_select)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  // SRAM contents as seen by the DUT, and the expected framebuffer
  logic [31:0] mem    [0:WORDS-1];
  logic [31:0] ref_fb [0:WORDS-1];

  int          rd_cnt    = 0;
  int          wr_cnt    = 0;
  int          bs_err    = 0;
  int          bad_addr  = 0;
  int          busy_cnt  = 0;
  int          max_busy  = 0;
  bit          force_busy = 1'b0;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] wr_addr_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // All stimulus and sampling happens just after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference address map: 4 words per row, 32 pixels per word, bit order
  // is the 5-bit column offset read backwards
  function automatic int ref_index(input int x, input int y);
    return y * 4 + x / 32;
  endfunction

  function automatic int ref_bit(input int x);
    int lo = x % 32;
    int r  = 0;
    for (int i = 0; i < 5; i++)
      if (((lo >> i) & 1) != 0) r += 1 << (4 - i);
    return r;
  endfunction

  // SRAM model: answers requests seen on the falling edge, optional busy
  initial begin
    int  idx;
    bit  in_rng;
    SRAM_busy    = 1'b0;
    SRAM_data_in = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        busy_cnt = 0;
      end else if (read_en || write_en) begin
        if (byte_select !== 4'hF) bs_err++;
        in_rng = (word_address_dest >= BASE) && (word_address_dest < BASE + WORDS);
        idx    = int'(word_address_dest - BASE);
        if (read_en) begin
          rd_cnt++;
          SRAM_data_in = in_rng ? mem[idx] : 32'h0;
        end
        if (write_en) begin
          wr_cnt++;
          last_wr_addr = word_address_dest;
          last_wr_data = data_out;
          wr_addr_q.push_back(word_address_dest);
          if (in_rng) mem[idx] = data_out;
          else        bad_addr++;
        end
        if (!in_rng) bad_addr++;
        busy_cnt = int'($urandom_range(0, max_busy));
      end else begin
        if (byte_select !== 4'h0) bs_err++;
        if (busy_cnt > 0) busy_cnt--;
      end
      SRAM_busy = force_busy || (busy_cnt > 0);
    end
  end

  // One pixel request from presentation to done, checked against the model
  task automatic do_pixel(input int x, input int y, input bit v, input int lat_exp, input string tag);
    int n;
    int rd0;
    int wr0;
    int idx;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    n   = 0;
    while (!pixel_ready && n < 100) begin tick(); n++; end
    check({tag, ":ready"}, {31'd0, pixel_ready}, 32'd1);
    pixel_x     = 7'(x);
    pixel_y     = 7'(y);
    pixel_value = v;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    n = 1;
    while (!pixel_done && n < 400) begin tick(); n++; end
    check({tag, ":done"}, {31'd0, pixel_done}, 32'd1);
    if (lat_exp > 0) check({tag, ":latency"}, n, lat_exp);
    if (y < ROWS) begin
      idx = ref_index(x, y);
      ref_fb[idx][ref_bit(x)] = v;
      check({tag, ":reads"}, rd_cnt - rd0, 32'd1);
      check({tag, ":writes"}, wr_cnt - wr0, 32'd1);
      check({tag, ":addr"}, last_wr_addr, BASE + idx);
      check({tag, ":data"}, last_wr_data, ref_fb[idx]);
    end else begin
      check({tag, ":reads"}, rd_cnt - rd0, 32'd0);
      check({tag, ":writes"}, wr_cnt - wr0, 32'd0);
    end
    tick();
    check({tag, ":done_pulse"}, {31'd0, pixel_done}, 32'd0);
  endtask

  initial begin
    int n;
    int rd0;
    int wr0;
    int cnt;
    int x;
    int y;
    int idx;
    bit v;

    nrst        = 1'b0;
    pixel_valid = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_value = 1'b0;
    VGA_state   = 2'd0;
`ifdef VGA_CLEAR_EN
    clear_req   = 1'b0;
`endif
    for (int i = 0; i < WORDS; i++) begin
      mem[i]    = $urandom;
      ref_fb[i] = mem[i];
    end

    // Reset state
    #12;
    check("rst:read_en",  {31'd0, read_en},  32'd0);
    check("rst:write_en", {31'd0, write_en}, 32'd0);
    check("rst:done",     {31'd0, pixel_done}, 32'd0);
    check("rst:addr",     word_address_dest, 32'd0);
    check("rst:byte_sel", {28'd0, byte_select}, 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    check("rst:ready", {31'd0, pixel_ready}, 32'd1);

    // Directed words from the address map
    mem[0] = 32'h0; ref_fb[0] = 32'h0;
    do_pixel(0, 0, 1'b1, 5, "p0_0");
    check("p0_0:addr_const", last_wr_addr, 32'h0000_3E80);
    check("p0_0:data_const", last_wr_data, 32'h0000_0001);

    mem[9] = 32'h0; ref_fb[9] = 32'h0;
    do_pixel(33, 2, 1'b1, 5, "p33_2");
    check("p33_2:addr_const", last_wr_addr, 32'h0000_3E89);
    check("p33_2:data_const", last_wr_data, 32'h0001_0000);

    // Last row: x=31 lands in the row's first word, x=127 in its last word
    mem[380] = 32'hFFFF_FFFF; ref_fb[380] = 32'hFFFF_FFFF;
    do_pixel(31, 95, 1'b0, 5, "p31_95");
    check("p31_95:addr_const", last_wr_addr, 32'h0000_3FFC);
    check("p31_95:data_const", last_wr_data, 32'h7FFF_FFFF);
    mem[383] = 32'hFFFF_FFFF; ref_fb[383] = 32'hFFFF_FFFF;
    do_pixel(127, 95, 1'b0, 5, "p127_95");
    check("p127_95:addr_const", last_wr_addr, 32'h0000_3FFF);
    check("p127_95:data_const", last_wr_data, 32'h7FFF_FFFF);

    // Rewriting an unchanged pixel still performs the write
    do_pixel(0, 0, 1'b1, 5, "p0_0_again");

    // Off-screen rows are dropped
    do_pixel(5, 100, 1'b1, 1, "drop_y100");
    do_pixel(64, 96, 1'b1, 1, "drop_y96");
    do_pixel(64, 127, 1'b0, 1, "drop_y127");

    // Display bus active at acceptance: wait, then start right after release
    VGA_state   = 2'd2;
    rd0         = rd_cnt;
    pixel_x     = 7'd10;
    pixel_y     = 7'd7;
    pixel_value = 1'b1;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      if (pixel_ready || read_en) cnt++;
      tick();
    end
    check("hold:ready_or_read_seen", cnt, 32'd0);
    check("hold:reads", rd_cnt - rd0, 32'd0);
    VGA_state = 2'd0;
    tick();
    check("hold:read_en_after_drop", {31'd0, read_en}, 32'd1);
    n = 0;
    while (!pixel_done && n < 100) begin tick(); n++; end
    check("hold:done", {31'd0, pixel_done}, 32'd1);
    idx = ref_index(10, 7);
    ref_fb[idx][ref_bit(10)] = 1'b1;
    check("hold:addr", last_wr_addr, BASE + idx);
    check("hold:data", last_wr_data, ref_fb[idx]);
    tick();

    // Reset while waiting on a busy read aborts the request
    force_busy  = 1'b1;
    wr0         = wr_cnt;
    pixel_x     = 7'd5;
    pixel_y     = 7'd10;
    pixel_value = 1'b1;
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
    nrst = 1'b0;
    #2;
    check("abort:read_en",  {31'd0, read_en},  32'd0);
    check("abort:write_en", {31'd0, write_en}, 32'd0);
    check("abort:addr",     word_address_dest, 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    force_busy = 1'b0;
    check("abort:ready", {31'd0, pixel_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (pixel_done || write_en) cnt++;
      tick();
    end
    check("abort:no_done_or_write", cnt, 32'd0);
    check("abort:writes", wr_cnt - wr0, 32'd0);

    // Randomized requests with random SRAM busy stretches
    for (int i = 0; i < 40; i++) begin
      max_busy = int'($urandom_range(0, 3));
      x = int'($urandom_range(0, 127));
      y = int'($urandom_range(0, 110));
      v = 1'($urandom_range(0, 1));
      do_pixel(x, y, v, (max_busy == 0) ? ((y < ROWS) ? 5 : 1) : 0, "rand");
    end
    max_busy = 0;

    // Whole framebuffer agrees with the model
    cnt = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_fb[i]) cnt++;
    check("fb:word_mismatches", cnt, 32'd0);

`ifdef VGA_CLEAR_EN
    // Clear has priority over a simultaneous pixel request
    tick();
    max_busy = 2;
    wr_addr_q.delete();
    wr0         = wr_cnt;
    clear_req   = 1'b1;
    pixel_valid = 1'b1;
    pixel_x     = 7'd3;
    pixel_y     = 7'd3;
    pixel_value = 1'b1;
    #1;
    check("clear:prio_ready", {31'd0, pixel_ready}, 32'd0);
    tick();
    clear_req   = 1'b0;
    pixel_valid = 1'b0;
    n   = 1;
    cnt = 0;
    while (!pixel_done && n < 4000) begin
      if (pixel_ready) cnt++;
      tick();
      n++;
    end
    check("clear:done", {31'd0, pixel_done}, 32'd1);
    check("clear:ready_seen", cnt, 32'd0);
    check("clear:writes", wr_cnt - wr0, WORDS);
    cnt = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] !== BASE + i) cnt++;
    check("clear:addr_order", cnt, 32'd0);
    cnt = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (mem[i] !== 32'h0) cnt++;
      ref_fb[i] = 32'h0;
    end
    check("clear:nonzero_words", cnt, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pixel_done) cnt++;
    end
    check("clear:extra_done", cnt, 32'd0);
    max_busy = 0;
    do_pixel(70, 40, 1'b1, 5, "post_clear");
`endif

    check("bus:byte_select_errors", bs_err, 32'd0);
    check("bus:out_of_range_addr", bad_addr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
